// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and widths.
// Imported by the arbiter, its result FIFOs and the bus interface. The reservation
// stations, map table and ROB import the same result/broadcast layouts.
package cdb_arbiter_pkg;

   localparam int unsigned ROB_TAG_W = 4;   // tag 0 reserved: no broadcast / value ready
   localparam int unsigned XLEN      = 32;

   typedef struct packed {
      logic [ROB_TAG_W-1:0] rob_tag;
      logic [XLEN-1:0]      value;
   } FU_RESULT;

   typedef struct packed {
      logic [ROB_TAG_W-1:0] rob_tag;
      logic [XLEN-1:0]      value;
   } CDB_DATA;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and CDB broadcast outputs.
//   fu_valid/fu_rob_tag/fu_value : per-unit completed result (driven by the units)
//   fu_ready                     : per-unit FIFO can accept this cycle
//   cdb                          : registered {rob_tag, value} broadcast
//   cdb_grant                    : one-hot source of the current cdb contents, 0 if idle
// master = functional-unit / consumer side, slave = arbiter side.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = 4
) ();

   logic [NUM_FU-1:0]                fu_valid;
   logic [NUM_FU-1:0][ROB_TAG_W-1:0] fu_rob_tag;
   logic [NUM_FU-1:0][XLEN-1:0]      fu_value;
   logic [NUM_FU-1:0]                fu_ready;
   CDB_DATA                          cdb;
   logic [NUM_FU-1:0]                cdb_grant;

   modport master (
      output fu_valid, fu_rob_tag, fu_value,
      input  fu_ready, cdb, cdb_grant
   );

   modport slave (
      input  fu_valid, fu_rob_tag, fu_value,
      output fu_ready, cdb, cdb_grant
   );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-unit result FIFO (module cdb_result_fifo).
//   clk, reset (async, active-low), clear (sync flush, priority over push/pop)
//   push/push_data : enqueue, ignored while full (even if popping this cycle)
//   pop            : dequeue, ignored while empty
//   empty/full     : decoded from the registered count only
//   head           : oldest entry
module cdb_result_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     clear,
   input  logic     push,
   input  FU_RESULT push_data,
   input  logic     pop,
   output logic     empty,
   output logic     full,
   output FU_RESULT head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   FU_RESULT         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: buffers each functional unit's results in its own FIFO and
// broadcasts at most one result per cycle, round-robin across units.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   squash : synchronous flush of all FIFOs, cdb, cdb_grant and rr_ptr
//   bus    : cdb_arbiter_if.slave (fu_valid/fu_rob_tag/fu_value in, fu_ready/cdb/cdb_grant out)
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU     = 4,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         squash,
   cdb_arbiter_if.slave bus
);

   localparam int unsigned RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   gnt_idx;
   logic [RR_W-1:0]   cand;
   logic [RR_W-1:0]   rr_next;
   logic              found;
   logic [NUM_FU-1:0] fifo_empty;
   logic [NUM_FU-1:0] fifo_full;
   logic [NUM_FU-1:0] pop;
   FU_RESULT          push_data [NUM_FU];
   FU_RESULT          fifo_head [NUM_FU];

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign push_data[i] = '{rob_tag: bus.fu_rob_tag[i], value: bus.fu_value[i]};
      assign pop[i]       = found && (gnt_idx == RR_W'(i));
      assign bus.fu_ready[i] = ~fifo_full[i];

      cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .clear     (squash),
         .push      (bus.fu_valid[i]),
         .push_data (push_data[i]),
         .pop       (pop[i]),
         .empty     (fifo_empty[i]),
         .full      (fifo_full[i]),
         .head      (fifo_head[i])
      );

      a_valid_tag_nonzero: assert property (@(posedge clk) disable iff (!reset)
         !(bus.fu_valid[i] && (bus.fu_rob_tag[i] == '0)));
   end

   // Scan rr_ptr, rr_ptr+1, ... modulo NUM_FU; modulo keeps non-power-of-2 NUM_FU correct.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         cand = RR_W'((32'(rr_ptr) + k) % NUM_FU);
         if (!found && !fifo_empty[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      rr_next = (gnt_idx == RR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.cdb       <= '0;
         bus.cdb_grant <= '0;
         rr_ptr        <= '0;
      end else if (squash) begin
         bus.cdb       <= '0;
         bus.cdb_grant <= '0;
         rr_ptr        <= '0;
      end else if (found) begin
         bus.cdb.rob_tag <= fifo_head[gnt_idx].rob_tag;
         bus.cdb.value   <= fifo_head[gnt_idx].value;
         bus.cdb_grant   <= NUM_FU'(1) << gnt_idx;
         rr_ptr          <= rr_next;
      end else begin
         bus.cdb       <= '0;
         bus.cdb_grant <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_FU=4, FIFO_DEPTH=2).
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic squash;
   int   total = 0;
   int   bad   = 0;

   cdb_arbiter_if #(.NUM_FU(4)) bus ();

   cdb_arbiter #(.NUM_FU(4), .FIFO_DEPTH(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .squash (squash),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] val(input int t);
      return 32'hA500_0000 + 32'(t) * 32'd3;
   endfunction

   function automatic logic [63:0] cx(input int t);
      if (t == 0) return 64'd0;
      return {28'd0, 4'(t), val(t)};
   endfunction

   function automatic logic [63:0] cobs();
      return {28'd0, bus.cdb.rob_tag, bus.cdb.value};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input int t);
      bus.fu_valid[u]   = 1'b1;
      bus.fu_rob_tag[u] = 4'(t);
      bus.fu_value[u]   = val(t);
   endtask

   task automatic idle();
      bus.fu_valid = '0;
   endtask

   task automatic step(input string n, input int t, input logic [3:0] g);
      tick();
      chk(n, cobs(), cx(t));
      chk({n, "_grant"}, 64'(bus.cdb_grant), 64'(g));
   endtask

   initial begin
      reset          = 1'b0;
      squash         = 1'b0;
      bus.fu_valid   = '0;
      bus.fu_rob_tag = '0;
      bus.fu_value   = '0;

      // 1. reset state, then idle bus
      #1;
      chk("rst_cdb",   cobs(), 64'd0);
      chk("rst_grant", 64'(bus.cdb_grant), 64'd0);
      chk("rst_ready", 64'(bus.fu_ready), 64'hF);
      #10 reset = 1'b1;
      step("idle0", 0, 4'b0000);
      step("idle1", 0, 4'b0000);

      // 2. single result from unit 1, no bypass, held one cycle
      drive(1, 3);
      tick();
      idle();
      chk("single_nobypass", cobs(), 64'd0);
      step("single_bcast", 3, 4'b0010);
      step("single_gone", 0, 4'b0000);

      // 3. contention from rr_ptr=0, then from rr_ptr=2
      squash = 1'b1;
      tick();
      squash = 1'b0;
      for (int u = 0; u < 4; u++) drive(u, u + 1);
      tick();
      idle();
      chk("rr0_nobypass", cobs(), 64'd0);
      step("rr0_a", 1, 4'b0001);
      step("rr0_b", 2, 4'b0010);
      step("rr0_c", 3, 4'b0100);
      step("rr0_d", 4, 4'b1000);
      chk("rr0_end_ptr", 64'(dut.rr_ptr), 64'd0);
      drive(1, 9);
      tick();
      idle();
      step("rr_seed", 9, 4'b0010);
      for (int u = 0; u < 4; u++) drive(u, u + 1);
      tick();
      idle();
      chk("rr2_ptr", 64'(dut.rr_ptr), 64'd2);
      step("rr2_a", 3, 4'b0100);
      step("rr2_b", 4, 4'b1000);
      step("rr2_c", 1, 4'b0001);
      step("rr2_d", 2, 4'b0010);
      step("rr2_idle", 0, 4'b0000);

      // 4. backpressure on unit 0 while units 1..3 stay non-empty
      drive(0, 5); drive(1, 10); drive(2, 12); drive(3, 14);
      tick();
      drive(0, 6); drive(1, 11); drive(2, 13); drive(3, 15);
      tick();
      chk("bp_e2", cobs(), cx(12));
      chk("bp_e2_ready", 64'(bus.fu_ready), 64'b0100);
      idle();
      drive(0, 7);
      step("bp_e3", 14, 4'b1000);
      chk("bp_e3_ready", 64'(bus.fu_ready), 64'b1100);
      step("bp_e4", 5, 4'b0001);
      chk("bp_e4_ready", 64'(bus.fu_ready), 64'b1101);
      step("bp_e5", 10, 4'b0010);
      chk("bp_e5_ready", 64'(bus.fu_ready), 64'b1110);
      idle();
      step("bp_e6", 13, 4'b0100);
      step("bp_e7", 15, 4'b1000);
      step("bp_e8", 6, 4'b0001);
      step("bp_e9", 11, 4'b0010);
      step("bp_e10", 7, 4'b0001);
      step("bp_e11", 0, 4'b0000);

      // 5. squash with FIFOs loaded; squash-cycle inputs dropped
      for (int u = 0; u < 4; u++) drive(u, u + 1);
      tick();
      for (int u = 0; u < 4; u++) drive(u, u + 5);
      tick();
      chk("sq_pre", cobs(), cx(2));
      chk("sq_pre_ready", 64'(bus.fu_ready), 64'b0010);
      squash = 1'b1;
      for (int u = 0; u < 4; u++) drive(u, u + 9);
      tick();
      squash = 1'b0;
      idle();
      chk("sq_cdb", cobs(), 64'd0);
      chk("sq_grant", 64'(bus.cdb_grant), 64'd0);
      chk("sq_ready", 64'(bus.fu_ready), 64'hF);
      chk("sq_ptr", 64'(dut.rr_ptr), 64'd0);
      step("sq_after0", 0, 4'b0000);
      step("sq_after1", 0, 4'b0000);
      step("sq_after2", 0, 4'b0000);

      // 6. async reset while cdb is nonzero
      drive(2, 6);
      tick();
      idle();
      step("ar_bcast", 6, 4'b0100);
      #3 reset = 1'b0;
      #1;
      chk("ar_cdb", cobs(), 64'd0);
      chk("ar_grant", 64'(bus.cdb_grant), 64'd0);
      chk("ar_ready", 64'(bus.fu_ready), 64'hF);
      #2 reset = 1'b1;
      step("ar_after", 0, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
